sample_loader: RTL and testbench

- Sequential front-end that collects regression samples one value at a time from `data_in` under button-style `enter` strobes.
- Packs the samples into the design matrix X (one x column plus a constant-1 column) and the target vector y.
- Raises `ready` once the operator confirms with `input_done`.
- Sits directly upstream of the transpose / X^T·X / X^T·y chain; `ready` drives the transpose `start`, and `x_data`/`y_data` drive its matrix inputs.

---
 rtl/sample_loader.sv | 189 ++++++++++++++++++
 tb/tb_sample_loader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_loader.sv
// Collects (x, y) regression samples from data_in on enter strobes and packs X (x | 1) and y.
// Define SAMPLE_LOADER_SYNC_EN to pass enter/input_done through 2-flop synchronizers.
module sample_loader #(
  parameter int ELEM_WIDTH  = 14,
  parameter int NUM_SAMPLES = 3,
  parameter int MAX_VAL     = 99
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enter,
  input  logic                                input_done,
  input  logic [ELEM_WIDTH-1:0]               data_in,
  output logic [NUM_SAMPLES*2*ELEM_WIDTH-1:0] x_data,
  output logic [NUM_SAMPLES*ELEM_WIDTH-1:0]   y_data,
  output logic                                error,
  output logic                                ready,
  output logic [$clog2(NUM_SAMPLES+1)-1:0]    sample_count
);

  localparam int CW = $clog2(NUM_SAMPLES+1);

  typedef enum logic [2:0] {
    WAIT_X = 3'd0,
    WAIT_Y = 3'd1,
    FULL   = 3'd2,
    DONE   = 3'd3,
    ERROR  = 3'd4
  } state_t;

  state_t                              r_state;
  state_t                              w_state_nxt;
  logic [NUM_SAMPLES*2*ELEM_WIDTH-1:0] r_x_buf;
  logic [NUM_SAMPLES*ELEM_WIDTH-1:0]   r_y_buf;
  logic [CW-1:0]                       r_count;
  logic                                r_error;
  logic                                r_ready;
  logic                                r_enter_q;
  logic                                r_done_q;
  logic                                w_enter;
  logic                                w_done;
  logic                                w_enter_rise;
  logic                                w_done_rise;
  logic                                w_in_range;
  logic                                w_cap_x;
  logic                                w_cap_y;
  logic                                w_clear;

`ifdef SAMPLE_LOADER_SYNC_EN
  logic [1:0] r_enter_sync;
  logic [1:0] r_done_sync;

  // Two-flop synchronizers for the asynchronous operator inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enter_sync <= 2'b00;
      r_done_sync  <= 2'b00;
    end else begin
      r_enter_sync <= {r_enter_sync[0], enter};
      r_done_sync  <= {r_done_sync[0], input_done};
    end
  end

  assign w_enter = r_enter_sync[1];
  assign w_done  = r_done_sync[1];
`else
  assign w_enter = enter;
  assign w_done  = input_done;
`endif

  // Edge-detect history so a held level yields a single event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enter_q <= 1'b0;
      r_done_q  <= 1'b0;
    end else begin
      r_enter_q <= w_enter;
      r_done_q  <= w_done;
    end
  end

  assign w_enter_rise = w_enter & ~r_enter_q;
  assign w_done_rise  = w_done & ~r_done_q;
  assign w_in_range   = (data_in <= ELEM_WIDTH'(MAX_VAL));

  // Next-state and capture control; enter_rise wins over a simultaneous done_rise
  always_comb begin
    w_state_nxt = r_state;
    w_cap_x     = 1'b0;
    w_cap_y     = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      WAIT_X: begin
        if (w_enter_rise) begin
          if (w_in_range) begin
            w_cap_x     = 1'b1;
            w_state_nxt = WAIT_Y;
          end else begin
            w_state_nxt = ERROR;
          end
        end else if (w_done_rise && (r_count < CW'(NUM_SAMPLES))) begin
          w_state_nxt = ERROR;
        end else begin
          w_state_nxt = r_state;
        end
      end
      WAIT_Y: begin
        if (w_enter_rise) begin
          if (w_in_range) begin
            w_cap_y = 1'b1;
            if ((r_count + CW'(1)) == CW'(NUM_SAMPLES)) begin
              w_state_nxt = FULL;
            end else begin
              w_state_nxt = WAIT_X;
            end
          end else begin
            w_state_nxt = ERROR;
          end
        end else if (w_done_rise) begin
          w_state_nxt = ERROR;
        end else begin
          w_state_nxt = r_state;
        end
      end
      FULL: begin
        if (w_enter_rise) begin
          w_state_nxt = ERROR;
        end else if (w_done_rise) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      DONE, ERROR: begin
        // Any enter restarts entry from scratch; its data value is discarded
        if (w_enter_rise) begin
          w_clear     = 1'b1;
          w_state_nxt = WAIT_X;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_clear     = 1'b1;
        w_state_nxt = WAIT_X;
      end
    endcase
  end

  // State, flags and sample buffers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= WAIT_X;
      r_x_buf <= '0;
      r_y_buf <= '0;
      r_count <= '0;
      r_error <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_error <= (w_state_nxt == ERROR);
      r_ready <= (w_state_nxt == DONE);
      if (w_clear) begin
        r_x_buf <= '0;
        r_y_buf <= '0;
        r_count <= '0;
      end else begin
        for (int i = 0; i < NUM_SAMPLES; i++) begin
          if (w_cap_x && (r_count == CW'(i))) begin
            r_x_buf[(2*i)*ELEM_WIDTH +: ELEM_WIDTH]   <= data_in;
            r_x_buf[(2*i+1)*ELEM_WIDTH +: ELEM_WIDTH] <= ELEM_WIDTH'(1);
          end
          if (w_cap_y && (r_count == CW'(i))) begin
            r_y_buf[i*ELEM_WIDTH +: ELEM_WIDTH] <= data_in;
          end
        end
        if (w_cap_y) begin
          r_count <= r_count + CW'(1);
        end
      end
    end
  end

  assign x_data       = r_x_buf;
  assign y_data       = r_y_buf;
  assign sample_count = r_count;
  assign error        = r_error;
  assign ready        = r_ready;

endmodule

// File: tb/tb_sample_loader.sv
// Randomized self-checking bench for sample_loader against a list-based reference model.
module tb_sample_loader;

  localparam int EW = 14;
  localparam int N  = 3;
  localparam int CW = $clog2(N+1);

  logic              clk;
  logic              rst;
  logic              enter;
  logic              input_done;
  logic [EW-1:0]     data_in;
  logic [N*2*EW-1:0] x_data;
  logic [N*EW-1:0]   y_data;
  logic              error;
  logic              ready;
  logic [CW-1:0]     sample_count;

  int total = 0;
  int bad   = 0;

  // Reference model: accepted values in entry order (x0,y0,x1,y1,...)
  int m_xs[N];
  int m_ys[N];
  int m_n;
  bit m_err;
  bit m_ready;

  sample_loader #(.ELEM_WIDTH(EW), .NUM_SAMPLES(N), .MAX_VAL(99)) dut (
    .clk(clk), .rst(rst), .enter(enter), .input_done(input_done), .data_in(data_in),
    .x_data(x_data), .y_data(y_data), .error(error), .ready(ready), .sample_count(sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_clear();
    m_n = 0; m_err = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < N; i++) begin m_xs[i] = 0; m_ys[i] = 0; end
  endfunction

  function automatic void model_enter(input int v);
    if (m_err || m_ready) model_clear();
    else if (m_n == 2*N) m_err = 1'b1;
    else if (v > 99) m_err = 1'b1;
    else begin
      if (m_n % 2 == 0) m_xs[m_n/2] = v; else m_ys[m_n/2] = v;
      m_n++;
    end
  endfunction

  function automatic void model_done();
    if (!(m_err || m_ready)) begin
      if (m_n == 2*N) m_ready = 1'b1; else m_err = 1'b1;
    end
  endfunction

  function automatic logic [N*2*EW-1:0] exp_x();
    logic [N*2*EW-1:0] r;
    r = '0;
    for (int i = 0; i < (m_n+1)/2; i++) begin
      r[(2*i)*EW +: EW]   = EW'(m_xs[i]);
      r[(2*i+1)*EW +: EW] = EW'(1);
    end
    return r;
  endfunction

  function automatic logic [N*EW-1:0] exp_y();
    logic [N*EW-1:0] r;
    r = '0;
    for (int i = 0; i < m_n/2; i++) r[i*EW +: EW] = EW'(m_ys[i]);
    return r;
  endfunction

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enter = 1'b0; input_done = 1'b0; data_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    settle();
  endtask

  task automatic pulse_enter(input int v);
    @(negedge clk);
    data_in = EW'(v); enter = 1'b1;
    repeat (2) @(negedge clk);
    enter = 1'b0;
    settle();
    model_enter(v);
  endtask

  task automatic pulse_done();
    @(negedge clk);
    input_done = 1'b1;
    repeat (2) @(negedge clk);
    input_done = 1'b0;
    settle();
    model_done();
  endtask

  task automatic pulse_both(input int v);
    @(negedge clk);
    data_in = EW'(v); enter = 1'b1; input_done = 1'b1;
    repeat (2) @(negedge clk);
    enter = 1'b0; input_done = 1'b0;
    settle();
    model_enter(v);
  endtask

  task automatic test_reset();
    rst = 1'b1; enter = 1'b0; input_done = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    total += 5;
    if (x_data !== '0) begin bad++; $display("FAIL reset_x: got %0h want 0", x_data); end
    if (y_data !== '0) begin bad++; $display("FAIL reset_y: got %0h want 0", y_data); end
    if (sample_count !== '0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", sample_count); end
    if (error !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b want 0", error); end
    if (ready !== 1'b0) begin bad++; $display("FAIL reset_rdy: got %0b want 0", ready); end
    rst = 1'b0;
    model_clear();
    settle();
  endtask

  task automatic test_basic();
    logic [N*2*EW-1:0] want_x;
    logic [N*EW-1:0]   want_y;
    want_x = {14'd1, 14'd8, 14'd1, 14'd5, 14'd1, 14'd2};
    want_y = {14'd9, 14'd6, 14'd3};
    do_reset();
    pulse_enter(2); pulse_enter(3); pulse_enter(5);
    pulse_enter(6); pulse_enter(8); pulse_enter(9);
    pulse_done();
    total += 5;
    if (x_data !== want_x) begin bad++; $display("FAIL basic_x: got %0h want %0h", x_data, want_x); end
    if (y_data !== want_y) begin bad++; $display("FAIL basic_y: got %0h want %0h", y_data, want_y); end
    if (sample_count !== CW'(3)) begin bad++; $display("FAIL basic_cnt: got %0d want 3", sample_count); end
    if (ready !== 1'b1) begin bad++; $display("FAIL basic_rdy: got %0b want 1", ready); end
    if (error !== 1'b0) begin bad++; $display("FAIL basic_err: got %0b want 0", error); end
  endtask

  task automatic test_early_done();
    do_reset();
    pulse_enter(2); pulse_enter(3);
    pulse_done();
    total += 2;
    if (error !== 1'b1) begin bad++; $display("FAIL early_err: got %0b want 1", error); end
    if (ready !== 1'b0) begin bad++; $display("FAIL early_rdy: got %0b want 0", ready); end
    pulse_enter(42);
    total += 3;
    if (error !== 1'b0) begin bad++; $display("FAIL recover_err: got %0b want 0", error); end
    if (sample_count !== '0) begin bad++; $display("FAIL recover_cnt: got %0d want 0", sample_count); end
    if (x_data !== '0) begin bad++; $display("FAIL recover_x: got %0h want 0", x_data); end
  endtask

  task automatic test_range();
    do_reset();
    pulse_enter(100);
    total += 1;
    if (error !== 1'b1) begin bad++; $display("FAIL range_100: got %0b want 1", error); end
    pulse_enter(0);
    pulse_enter(99);
    total += 2;
    if (x_data[EW-1:0] !== EW'(99)) begin bad++; $display("FAIL range_99: got %0d want 99", x_data[EW-1:0]); end
    if (x_data[2*EW-1:EW] !== EW'(1)) begin bad++; $display("FAIL range_one: got %0d want 1", x_data[2*EW-1:EW]); end
    pulse_enter(0);
    total += 2;
    if (y_data[EW-1:0] !== EW'(0)) begin bad++; $display("FAIL range_zero: got %0d want 0", y_data[EW-1:0]); end
    if (sample_count !== CW'(1)) begin bad++; $display("FAIL range_cnt: got %0d want 1", sample_count); end
  endtask

  task automatic test_hold();
    do_reset();
    @(negedge clk);
    data_in = EW'(4); enter = 1'b1;
    repeat (10) @(negedge clk);
    enter = 1'b0;
    settle();
    model_enter(4);
    total += 1;
    if (sample_count !== '0) begin bad++; $display("FAIL hold_cnt0: got %0d want 0", sample_count); end
    pulse_enter(7);
    total += 3;
    if (sample_count !== CW'(1)) begin bad++; $display("FAIL hold_cnt1: got %0d want 1", sample_count); end
    if (x_data !== exp_x()) begin bad++; $display("FAIL hold_x: got %0h want %0h", x_data, exp_x()); end
    if (y_data[EW-1:0] !== EW'(7)) begin bad++; $display("FAIL hold_y: got %0d want 7", y_data[EW-1:0]); end
  endtask

  task automatic test_reenter();
    int lat;
`ifdef SAMPLE_LOADER_SYNC_EN
    lat = 3;
`else
    lat = 1;
`endif
    do_reset();
    for (int i = 0; i < 2*N; i++) pulse_enter(10 + i);
    pulse_done();
    total += 1;
    if (ready !== 1'b1) begin bad++; $display("FAIL reenter_rdy1: got %0b want 1", ready); end
    @(negedge clk);
    data_in = EW'(55); enter = 1'b1;
    repeat (lat - 1) @(negedge clk);
    total += 1;
    if (ready !== 1'b1) begin bad++; $display("FAIL reenter_early: got %0b want 1", ready); end
    @(negedge clk);
    total += 1;
    if (ready !== 1'b0) begin bad++; $display("FAIL reenter_drop: got %0b want 0", ready); end
    enter = 1'b0;
    settle();
    model_enter(55);
    total += 3;
    if (x_data !== '0) begin bad++; $display("FAIL reenter_x: got %0h want 0", x_data); end
    if (y_data !== '0) begin bad++; $display("FAIL reenter_y: got %0h want 0", y_data); end
    if (sample_count !== '0) begin bad++; $display("FAIL reenter_cnt: got %0d want 0", sample_count); end
    for (int i = 0; i < 2*N; i++) pulse_enter(20 + i);
    pulse_done();
    total += 2;
    if (ready !== 1'b1) begin bad++; $display("FAIL reenter_rdy2: got %0b want 1", ready); end
    if (x_data !== exp_x()) begin bad++; $display("FAIL reenter_x2: got %0h want %0h", x_data, exp_x()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse_enter(1); pulse_enter(2); pulse_enter(3); pulse_enter(4); pulse_enter(5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total += 4;
    if (x_data !== '0) begin bad++; $display("FAIL mid_x: got %0h want 0", x_data); end
    if (y_data !== '0) begin bad++; $display("FAIL mid_y: got %0h want 0", y_data); end
    if (sample_count !== '0) begin bad++; $display("FAIL mid_cnt: got %0d want 0", sample_count); end
    if (ready !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL mid_flags: got %0b%0b want 00", ready, error); end
    rst = 1'b0;
    model_clear();
    settle();
    pulse_enter(11); pulse_enter(12);
    total += 2;
    if (sample_count !== CW'(1)) begin bad++; $display("FAIL mid_cnt_after: got %0d want 1", sample_count); end
    if (x_data !== exp_x()) begin bad++; $display("FAIL mid_x_after: got %0h want %0h", x_data, exp_x()); end
  endtask

  task automatic test_random();
    int r;
    int v;
    do_reset();
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 19) == 0) v = $urandom_range(100, 16383);
      else v = $urandom_range(0, 99);
      if (r < 2) pulse_done();
      else if (r == 2) pulse_both(v);
      else pulse_enter(v);
      total += 5;
      if (x_data !== exp_x()) begin bad++; $display("FAIL rand_x[%0d]: got %0h want %0h", k, x_data, exp_x()); end
      if (y_data !== exp_y()) begin bad++; $display("FAIL rand_y[%0d]: got %0h want %0h", k, y_data, exp_y()); end
      if (sample_count !== CW'(m_n/2)) begin bad++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", k, sample_count, m_n/2); end
      if (error !== m_err) begin bad++; $display("FAIL rand_err[%0d]: got %0b want %0b", k, error, m_err); end
      if (ready !== m_ready) begin bad++; $display("FAIL rand_rdy[%0d]: got %0b want %0b", k, ready, m_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_early_done();
    test_range();
    test_hold();
    test_reenter();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
